// File: rtl/usb_tx_encoder_p.sv
// usb_tx_encoder_p: USB full-speed transmit encoder (byte serialiser, bit stuffer, NRZI, EOP).
// Defining USB_TX_SYNC_EN makes the encoder emit the SYNC pattern itself ahead of the first byte.
module usb_tx_encoder_p #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_hold,
  output logic       tx_err,
  output logic       d_plus_out,
  output logic       d_minus_out
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       STUFF_MAX = 4'(STUFF_LEN);
  localparam logic [2:0]       SE0_LAST  = 3'(EOP_SE0_BITS - 1);

`ifdef USB_TX_SYNC_EN
  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
`else
  typedef enum logic [2:0] {IDLE, DATA, STUFF, EOP_SE0, EOP_J} state_t;
`endif

  state_t           state_q, state_n, after_st;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [3:0]       bit_idx_q, bit_idx_n;
  logic [3:0]       ones_q, ones_n;
  logic [2:0]       se0_q, se0_n;
  logic             last_q, last_n;
  logic             nrzi_q, nrzi_n;
  logic             dp_q, dp_n;
  logic             dm_q, dm_n;
  logic             busy_q, busy_n;
  logic             hold_q, hold_n;
  logic             err_q, err_n;
  logic [7:0]       shift_q, shift_n;
  logic [7:0]       hold_data;
  logic             hold_last;
  logic             hold_full;
  logic             take_hold;
  logic             accept;
  logic             tick;
  logic             send_en;
  logic             send_bit;

  assign accept = tx_valid && !hold_full;
  // A tick marks the start of a new bit period; all line changes happen on it.
  assign tick   = (state_q != IDLE) && (cnt_q == CNT_MAX);

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    bit_idx_n = bit_idx_q;
    ones_n    = ones_q;
    se0_n     = se0_q;
    last_n    = last_q;
    nrzi_n    = nrzi_q;
    dp_n      = dp_q;
    dm_n      = dm_q;
    busy_n    = busy_q;
    hold_n    = hold_q;
    err_n     = 1'b0;
    shift_n   = shift_q;
    take_hold = 1'b0;
    send_en   = 1'b0;
    send_bit  = 1'b0;
    after_st  = DATA;

    if (state_q != IDLE) cnt_n = tick ? '0 : cnt_q + 1'b1;
    if (tick) begin
      busy_n = 1'b1;
      hold_n = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (hold_full) begin
          take_hold = 1'b1;
          shift_n   = hold_data;
          last_n    = hold_last;
          bit_idx_n = '0;
          ones_n    = '0;
          nrzi_n    = 1'b1;
          cnt_n     = CNT_MAX;
`ifdef USB_TX_SYNC_EN
          state_n   = SYNC;
`else
          state_n   = DATA;
`endif
        end
      end
`ifdef USB_TX_SYNC_EN
      SYNC: begin
        if (tick) begin
          send_en  = 1'b1;
          send_bit = (bit_idx_q == 4'd7);
          if (bit_idx_q == 4'd7) begin
            bit_idx_n = '0;
            after_st  = DATA;
          end else begin
            bit_idx_n = bit_idx_q + 4'd1;
            after_st  = SYNC;
          end
        end
      end
`endif
      DATA: begin
        if (tick) begin
          // bit_idx == 8 means the previous byte (and any stuff bit it caused) is finished.
          if (bit_idx_q == 4'd8) begin
            if (!last_q && hold_full) begin
              take_hold = 1'b1;
              send_en   = 1'b1;
              send_bit  = hold_data[0];
              shift_n   = {1'b0, hold_data[7:1]};
              last_n    = hold_last;
              bit_idx_n = 4'd1;
            end else begin
              err_n   = !last_q;
              state_n = EOP_SE0;
              se0_n   = '0;
              dp_n    = 1'b0;
              dm_n    = 1'b0;
            end
          end else begin
            send_en   = 1'b1;
            send_bit  = shift_q[0];
            shift_n   = {1'b0, shift_q[7:1]};
            bit_idx_n = bit_idx_q + 4'd1;
          end
        end
      end
      STUFF: begin
        if (tick) begin
          nrzi_n  = !nrzi_q;
          dp_n    = !nrzi_q;
          dm_n    = nrzi_q;
          ones_n  = '0;
          hold_n  = 1'b1;
          state_n = DATA;
        end
      end
      EOP_SE0: begin
        if (tick) begin
          if (se0_q == SE0_LAST) begin
            state_n = EOP_J;
            nrzi_n  = 1'b1;
            dp_n    = 1'b1;
            dm_n    = 1'b0;
          end else begin
            se0_n = se0_q + 3'd1;
          end
        end
      end
      EOP_J: begin
        if (tick) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    // NRZI: a 0 toggles the line, a 1 holds it and feeds the stuffing run counter.
    if (send_en) begin
      if (send_bit) begin
        ones_n  = ones_q + 4'd1;
        state_n = (ones_n == STUFF_MAX) ? STUFF : after_st;
      end else begin
        nrzi_n  = !nrzi_q;
        ones_n  = '0;
        state_n = after_st;
      end
      dp_n = nrzi_n;
      dm_n = !nrzi_n;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      ones_q    <= '0;
      se0_q     <= '0;
      last_q    <= 1'b0;
      nrzi_q    <= 1'b1;
      dp_q      <= 1'b1;
      dm_q      <= 1'b0;
      busy_q    <= 1'b0;
      hold_q    <= 1'b0;
      err_q     <= 1'b0;
      hold_full <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      bit_idx_q <= bit_idx_n;
      ones_q    <= ones_n;
      se0_q     <= se0_n;
      last_q    <= last_n;
      nrzi_q    <= nrzi_n;
      dp_q      <= dp_n;
      dm_q      <= dm_n;
      busy_q    <= busy_n;
      hold_q    <= hold_n;
      err_q     <= err_n;
      if (take_hold) hold_full <= 1'b0;
      else if (accept) hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= tx_data;
      hold_last <= tx_last;
    end
    shift_q <= shift_n;
  end

  assign tx_ready    = !hold_full;
  assign tx_busy     = busy_q;
  assign tx_hold     = hold_q;
  assign tx_err      = err_q;
  assign d_plus_out  = dp_q;
  assign d_minus_out = dm_q;

endmodule

// File: doc/usb_tx_encoder_p.md
# usb_tx_encoder_p

Parametrised USB full-speed transmit encoder, the next generation of the bit-serial USB encoder. It accepts packet bytes over a valid/ready handshake and serialises them LSB-first. It applies bit stuffing with a configurable run length and NRZI-encodes the result onto the D+/D- lines. It generates EOP with a configurable SE0 length and sits between the packet builder and the USB line driver.

## Interface
- CLKS_PER_BIT, 8, clock cycles per USB bit time; legal values ≥2.
- STUFF_LEN, 6, consecutive transmitted 1s that force a stuffed 0; legal range 1..15.
- EOP_SE0_BITS, 2, SE0 length of EOP in bit times; legal range 1..4.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- tx_data  in  8  packet byte.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_last  in  1  byte is final of packet.
- tx_ready  out  1  holding register empty; a byte is accepted on a cycle with tx_valid && tx_ready.
- tx_busy  out  1  packet in progress, from packet start through the end of the EOP J bit.
- tx_hold  out  1  high for the whole bit period of a stuffed bit.
- tx_err  out  1  one-cycle underrun pulse.
- d_plus_out  out  1  D+ line.
- d_minus_out  out  1  D- line.

## Operation
- **Datapath:** one-byte holding register (hold_data, hold_last, hold_full) feeds an 8-bit shift register.
- **tx_ready:** tx_ready = !hold_full.
- **States:** IDLE, SYNC (only with the macro), DATA, STUFF, EOP_SE0, EOP_J.
- **IDLE:** lines at J (D+=1, D-=0). When hold_full is set, move the hold register into the shift register, clear hold_full, and enter SYNC or DATA. The ones counter is set to 0.
- **DATA:** shifts out the LSB each bit time.
  - A 0 toggles the line state (J↔K) and clears the ones counter.
  - A 1 holds the line state and increments the ones counter.
  - When the counter reaches STUFF_LEN, the next bit period is STUFF: the line toggles, tx_hold=1, the counter clears, and data does not advance.
- **Byte boundary (8th bit done, including any stuff bit it triggers):**
  - Current byte last: go to EOP_SE0.
  - Else hold_full: reload the shift register and continue DATA with no gap.
  - Else underrun: pulse tx_err and go to EOP_SE0.
- **EOP:** EOP_SE0 drives D+=D-=0 for EOP_SE0_BITS bit times, then EOP_J drives J for 1 bit time, then IDLE. tx_busy clears on entry to IDLE.
- **Encoding rules:**
  - NRZI state persists across bytes.
  - Each packet begins from J.
  - K = D+=0, D-=1.
- **Handshake:** tx_valid while tx_ready=0 is ignored (not latched).

## Timing
- **Reset values:** d_plus_out=1, d_minus_out=0, tx_ready=1, tx_busy=0, tx_hold=0, tx_err=0, state IDLE, hold_full=0, counters 0.
- **Bit-period counter:** runs 0..CLKS_PER_BIT-1; the line output is registered and changes only at counter wrap. Every bit, stuff bit, and EOP bit lasts exactly CLKS_PER_BIT cycles.
- **Latency:** byte accepted at edge T (IDLE) → tx_busy=1 and the first bit on the lines at edge T+2.
- **Hold register:** after the shift-register load, tx_ready returns to 1 one cycle later, so the next byte can be accepted during the current byte.
- **Stuff bit after final data bit:** transmitted before EOP.
- **Back-to-back packets:** the next packet may start the cycle after IDLE is entered.
- **Reset mid-operation:** outputs return to reset values immediately; the partial packet is discarded.

## Configuration
- **USB_TX_SYNC_EN defined:** SYNC state transmits 0x80 LSB-first before the first data byte (lines K J K J K J K K). The final SYNC 1 counts toward the ones counter.
- **USB_TX_SYNC_EN undefined:** no SYNC state; IDLE goes directly to DATA, and the upstream block supplies SYNC as data.

## Test plan
- **Reset and idle:** assert n_rst=0 mid-packet → lines J, tx_ready=1, tx_busy=0 immediately. Release reset with no input → lines stay J.
- **Single zero byte:** 0x00 with tx_last, macro off, CLKS_PER_BIT=8 → K J K J K J K J, 8 cycles each. Then SE0 for 16 cycles, J for 8 cycles, then tx_busy=0.
- **Bit stuffing:** 0xFF, 0xFF (last) → J×6, stuff K (tx_hold=1 for 8 cycles), K×6, stuff J, J×4. That is 18 bit periods before SE0.
- **Back-to-back bytes:** 0x01, 0x02, 0x03 (last) with tx_valid held → no idle bit between bytes, tx_ready low while the hold register is full, exactly 24 data bit periods.
- **Underrun:** 0x55 without tx_last and no further byte → tx_err is a one-cycle pulse at the byte boundary, followed by SE0 SE0 J, then IDLE.
- **SYNC insertion:** with USB_TX_SYNC_EN defined, 0xA5 (last) → K J K J K J K K precedes the data bits of 0xA5 encoded from state K.
